// File: rtl/cro_puf_pkg.sv
// Shared types and default constants for the CRO PUF measurement sequencer.
// The DEF_* constants are also used by the AXI slave register map.
package cro_puf_pkg;

  localparam int DEF_N_RO          = 16;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_RESP_BITS     = 32;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_WIN_CYCLES    = 4096;
  localparam int DEF_SYNC_CYCLES   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SETTLE,
    S_MEASURE,
    S_HOLD,
    S_COMPARE,
    S_DONE
  } cro_state_t;

  // Select width L for an oscillator array of n_ro entries.
  function automatic int sel_w(input int n_ro);
    return $clog2(n_ro);
  endfunction

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int DEF_SEL_W = sel_w(DEF_N_RO);

endpackage

// File: rtl/cro_puf_timer.sv
// Loadable down-counter: load the terminal-count offset, zero marks the last
// cycle of the interval. Shared by the SETTLE, MEASURE and HOLD phases.
module cro_puf_timer
  import cro_puf_pkg::*;
#(
  parameter int W = idx_w(DEF_WIN_CYCLES)
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cro_puf_ctrl.sv
// CRO PUF measurement sequencer: walks RESP_BITS oscillator-pair measurements
// per challenge and publishes the response word and tie count on completion.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; outputs quiet
// S_SETUP   | one cycle, counters cleared, oscillators off, selects set
// S_SETTLE  | oscillators running, counters gated off
// S_MEASURE | oscillators running, counters counting for the window
// S_HOLD    | everything stopped while counts cross into ACLK
// S_COMPARE | one cycle, compare counts and shift the response bit in
// S_DONE    | one cycle, publish response and tie count
module cro_puf_ctrl
  import cro_puf_pkg::*;
#(
  parameter int  N_RO          = DEF_N_RO,
  parameter int  CNT_W         = DEF_CNT_W,
  parameter int  RESP_BITS     = DEF_RESP_BITS,
  parameter int  SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int  WIN_CYCLES    = DEF_WIN_CYCLES,
  parameter int  SYNC_CYCLES   = DEF_SYNC_CYCLES,
  localparam int L             = sel_w(N_RO)
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2*L-1:0]       challenge,
  output logic [L-1:0]         ro_sel_a,
  output logic [L-1:0]         ro_sel_b,
  output logic                 ro_en,
  output logic                 cnt_clr,
  output logic                 cnt_en,
  input  logic [CNT_W-1:0]     cnt_a,
  input  logic [CNT_W-1:0]     cnt_b,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [7:0]           tie_cnt
);

  localparam int IDX_W = idx_w(RESP_BITS);
  localparam int TMR_W = idx_w(max3(SETTLE_CYCLES, WIN_CYCLES, SYNC_CYCLES));

  cro_state_t state_q;

  logic [L-1:0]         base_a_q, base_b_q;
  logic [IDX_W-1:0]     idx_q;
  logic [RESP_BITS-1:0] sr_q;
  logic [7:0]           tie_q;

  logic [L-1:0]         ro_sel_a_q, ro_sel_b_q;
  logic                 ro_en_q, cnt_clr_q, cnt_en_q;
  logic                 busy_q, done_q;
  logic [RESP_BITS-1:0] response_q;
  logic [7:0]           tie_cnt_q;

  logic [L-1:0]         nb_a, nb_b, pa, pb_raw, pb;
  logic [IDX_W-1:0]     n_idx;
  logic                 last_bit;

  logic                 tmr_load, tmr_zero;
  logic [TMR_W-1:0]     tmr_val;

  // Pair for the bit about to start: bit 0 from the live challenge in IDLE,
  // otherwise the next bit from the latched bases. Wraps mod N_RO by width.
  always_comb begin
    if (state_q == S_IDLE) begin
      nb_a  = challenge[L-1:0];
      nb_b  = challenge[2*L-1:L];
      n_idx = '0;
    end else begin
      nb_a  = base_a_q;
      nb_b  = base_b_q;
      n_idx = idx_q + IDX_W'(1);
    end
    pa     = nb_a + L'(n_idx);
    pb_raw = nb_b + L'(n_idx);
    pb     = (pb_raw == pa) ? pa + L'(1) : pb_raw;
  end

  assign last_bit = (idx_q == IDX_W'(RESP_BITS - 1));

  // Timer is loaded with (duration - 1) on the cycle before each timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: begin
        tmr_load = tmr_zero;
        tmr_val  = TMR_W'(WIN_CYCLES - 1);
      end
      S_MEASURE: begin
        tmr_load = tmr_zero;
        tmr_val  = TMR_W'(SYNC_CYCLES - 1);
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  cro_puf_timer #(
    .W(TMR_W)
  ) u_timer (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      base_a_q   <= '0;
      base_b_q   <= '0;
      idx_q      <= '0;
      sr_q       <= '0;
      tie_q      <= '0;
      ro_sel_a_q <= '0;
      ro_sel_b_q <= '0;
      ro_en_q    <= 1'b0;
      cnt_clr_q  <= 1'b0;
      cnt_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= '0;
      tie_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q   <= S_IDLE;
        ro_en_q   <= 1'b0;
        cnt_clr_q <= 1'b0;
        cnt_en_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // busy_q is still high during the done pulse, so a start then is ignored
            if (start && !abort && !busy_q) begin
              state_q    <= S_SETUP;
              base_a_q   <= nb_a;
              base_b_q   <= nb_b;
              idx_q      <= '0;
              sr_q       <= '0;
              tie_q      <= '0;
              ro_sel_a_q <= pa;
              ro_sel_b_q <= pb;
              cnt_clr_q  <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              busy_q <= 1'b0;
            end
          end
          S_SETUP: begin
            state_q   <= S_SETTLE;
            cnt_clr_q <= 1'b0;
            ro_en_q   <= 1'b1;
          end
          S_SETTLE: begin
            if (tmr_zero) begin
              state_q  <= S_MEASURE;
              cnt_en_q <= 1'b1;
            end
          end
          S_MEASURE: begin
            if (tmr_zero) begin
              state_q  <= S_HOLD;
              ro_en_q  <= 1'b0;
              cnt_en_q <= 1'b0;
            end
          end
          S_HOLD: begin
            if (tmr_zero) begin
              state_q <= S_COMPARE;
            end
          end
          S_COMPARE: begin
            sr_q <= {sr_q[RESP_BITS-2:0], (cnt_a > cnt_b)};
            if (cnt_a == cnt_b && tie_q != 8'hFF) begin
              tie_q <= tie_q + 8'd1;
            end
            if (last_bit) begin
              state_q <= S_DONE;
            end else begin
              state_q    <= S_SETUP;
              idx_q      <= n_idx;
              ro_sel_a_q <= pa;
              ro_sel_b_q <= pb;
              cnt_clr_q  <= 1'b1;
            end
          end
          S_DONE: begin
            state_q    <= S_IDLE;
            response_q <= sr_q;
            tie_cnt_q  <= tie_q;
            done_q     <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ro_sel_a = ro_sel_a_q;
  assign ro_sel_b = ro_sel_b_q;
  assign ro_en    = ro_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign cnt_en   = cnt_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign tie_cnt  = tie_cnt_q;

endmodule

// File: tb/tb_cro_puf_ctrl.sv
// Scoreboard bench for cro_puf_ctrl: stimulus pushes expected pairs and
// results, negedge monitors pop and compare as the DUT presents them.
module tb_cro_puf_ctrl;

  localparam int N_RO = 8;
  localparam int CW   = 16;
  localparam int RB   = 4;
  localparam int ST   = 2;
  localparam int WN   = 16;
  localparam int SY   = 2;
  localparam int P    = 2 + ST + WN + SY;
  localparam int LAT  = RB * P + 1;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start, abort;
  logic [5:0]  challenge;
  logic [2:0]  ro_sel_a, ro_sel_b;
  logic        ro_en, cnt_clr, cnt_en;
  logic [15:0] cnt_a, cnt_b;
  logic        busy, done;
  logic [3:0]  response;
  logic [7:0]  tie_cnt;

  cro_puf_ctrl #(
    .N_RO(N_RO), .CNT_W(CW), .RESP_BITS(RB),
    .SETTLE_CYCLES(ST), .WIN_CYCLES(WN), .SYNC_CYCLES(SY)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
    .challenge(challenge), .ro_sel_a(ro_sel_a), .ro_sel_b(ro_sel_b),
    .ro_en(ro_en), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy), .done(done),
    .response(response), .tie_cnt(tie_cnt)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Environment counter model: 0 = cnt_a wins iff ro_sel_a odd, 1 = all ties,
  // 2 = per-oscillator counts from freq[].
  int          mode = 0;
  logic [15:0] freq [8];

  always_comb begin
    cnt_a = 16'd0;
    cnt_b = 16'd0;
    case (mode)
      0: begin
        cnt_a = ro_sel_a[0] ? 16'd200 : 16'd100;
        cnt_b = 16'd150;
      end
      1: begin
        cnt_a = 16'd100;
        cnt_b = 16'd100;
      end
      default: begin
        cnt_a = freq[ro_sel_a];
        cnt_b = freq[ro_sel_b];
      end
    endcase
  end

  typedef struct {
    logic [3:0] resp;
    logic [7:0] tie;
    int         e;
  } res_t;

  res_t       res_q[$];
  logic [5:0] pair_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int disrupt = 0;
  logic [3:0] last_resp = 4'd0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, got, got, exp, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: event occurred with nothing expected at cycle %0d", nm, cyc);
  endtask

  function automatic logic [5:0] pair_of(input logic [5:0] ch, input int i);
    int a, b;
    a = (int'(ch[2:0]) + i) % N_RO;
    b = (int'(ch[5:3]) + i) % N_RO;
    if (a == b) b = (a + 1) % N_RO;
    return {a[2:0], b[2:0]};
  endfunction

  function automatic logic [15:0] cnt_val(input logic [2:0] s, input bit is_a);
    if (mode == 0) return is_a ? (s[0] ? 16'd200 : 16'd100) : 16'd150;
    if (mode == 1) return 16'd100;
    return freq[s];
  endfunction

  // Monitor: pairs at each SETUP, phase lengths per bit, results at done.
  initial begin
    int ro_n, en_n, seen;
    bit have_prev;
    logic [5:0] p;
    res_t r;
    ro_n = 0; en_n = 0; seen = 0; have_prev = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (cnt_clr || done) begin
          if (have_prev && seen == disrupt) begin
            chk("ro_en_cycles", ro_n, ST + WN);
            chk("cnt_en_cycles", en_n, WN);
          end
          ro_n = 0; en_n = 0; seen = disrupt;
          have_prev = cnt_clr;
        end else begin
          ro_n += int'(ro_en);
          en_n += int'(cnt_en);
        end
        if (cnt_clr) begin
          if (pair_q.size() == 0) fail_now("unexpected_pair");
          else begin
            p = pair_q.pop_front();
            chk("pair_sel", int'({ro_sel_a, ro_sel_b}), int'(p));
          end
        end
        if (done) begin
          if (res_q.size() == 0) fail_now("unexpected_done");
          else begin
            r = res_q.pop_front();
            chk("response", int'(response), int'(r.resp));
            chk("tie_cnt", int'(tie_cnt), int'(r.tie));
            chk("done_latency", cyc - r.e, LAT);
            chk("busy_with_done", int'(busy), 1);
            last_resp = r.resp;
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 400 && cyc < target; k++) @(negedge ACLK);
    chk("reach_cycle", cyc, target);
  endtask

  task automatic do_run(input logic [5:0] ch, input int md, input int abort_bit, input bit stray);
    res_t r;
    logic [15:0] ca, cb;
    logic [5:0] p;
    int nb;
    mode = md;
    r.resp = 4'd0;
    r.tie  = 8'd0;
    nb = (abort_bit >= 0) ? abort_bit + 1 : RB;
    for (int i = 0; i < RB; i++) begin
      p  = pair_of(ch, i);
      ca = cnt_val(p[5:3], 1'b1);
      cb = cnt_val(p[2:0], 1'b0);
      r.resp[RB-1-i] = (ca > cb);
      if (ca == cb) r.tie = r.tie + 8'd1;
      if (i < nb) pair_q.push_back(p);
    end
    @(negedge ACLK);
    challenge = ch;
    start = 1'b1;
    r.e = cyc + 1;
    if (abort_bit < 0) res_q.push_back(r);
    @(negedge ACLK);
    start = 1'b0;
    challenge = 6'($urandom);
    chk("busy_rise", int'(busy), 1);
    if (stray) begin
      wait_cyc(r.e + 30);
      start = 1'b1;
      challenge = ch ^ 6'h3F;
      @(negedge ACLK);
      start = 1'b0;
    end
    if (abort_bit >= 0) begin
      wait_cyc(r.e + abort_bit * P + 8);
      abort = 1'b1;
      disrupt++;
      @(negedge ACLK);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_ro_en", int'(ro_en), 0);
      chk("abort_cnt_en", int'(cnt_en), 0);
      chk("abort_resp_kept", int'(response), int'(last_resp));
      repeat (120) @(negedge ACLK);
      chk("abort_no_done_resp", int'(response), int'(last_resp));
    end else begin
      for (int k = 0; k < 200 && busy; k++) @(negedge ACLK);
      chk("run_finished", int'(busy), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    ARESET = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    challenge = 6'd0;
    for (int k = 0; k < 8; k++) freq[k] = 16'd0;
    repeat (3) @(negedge ACLK);
    chk("reset_outputs", int'({ro_sel_a, ro_sel_b, ro_en, cnt_clr, cnt_en, busy, done, response, tie_cnt}), 0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    do_run(6'b011_001, 0, -1, 1'b0);
    chk("basic_response", int'(response), 4'b1010);
    do_run({3'd5, 3'd5}, 0, -1, 1'b0);
    do_run(6'($urandom), 1, -1, 1'b0);
    chk("ties_tie_cnt", int'(tie_cnt), 4);
    do_run(6'b011_001, 0, -1, 1'b1);
    do_run(6'($urandom), 0, 2, 1'b0);
    for (int k = 0; k < 8; k++) freq[k] = 16'($urandom_range(0, 3) * 100);
    do_run(6'($urandom), 2, -1, 1'b0);

    @(negedge ACLK);
    start = 1'b1;
    abort = 1'b1;
    challenge = 6'($urandom);
    @(negedge ACLK);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    repeat (5) @(negedge ACLK);
    chk("start_abort_still_idle", int'(busy), 0);

    mode = 0;
    @(negedge ACLK);
    challenge = 6'b011_001;
    start = 1'b1;
    e = cyc + 1;
    pair_q.push_back(pair_of(6'b011_001, 0));
    @(negedge ACLK);
    start = 1'b0;
    @(negedge ACLK);
    chk("settle_before_reset", int'(ro_en), 1);
    #2 ARESET = 1'b1;
    disrupt++;
    #1;
    chk("async_reset_outputs", int'({ro_sel_a, ro_sel_b, ro_en, cnt_clr, cnt_en, busy, done, response, tie_cnt}), 0);
    pair_q.delete();
    res_q.delete();
    last_resp = 4'd0;
    @(negedge ACLK);
    ARESET = 1'b0;
    chk("reset_run_started", e - e + int'(busy), 0);
    do_run(6'b011_001, 0, -1, 1'b0);

    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 8; k++) freq[k] = 16'($urandom_range(0, 3) * 100);
      do_run(6'($urandom), 2, -1, ($urandom_range(0, 1) == 1));
    end

    repeat (4) @(negedge ACLK);
    chk("pairs_drained", pair_q.size(), 0);
    chk("results_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
